// File: rtl/pr_freeze_pkg.sv
// Shared types and helpers for the PR freeze/isolation bridge.
package pr_freeze_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FROZEN = 2'd2
    } t_frz_state;

    // Width of a counter that must hold values 0..max_outst inclusive.
    function automatic int CNT_W(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

    // Width of the drain timer; never narrower than one bit.
    function automatic int tmr_w(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    // Low bit of channel ch inside a flat bus of w bits per channel.
    function automatic int slice_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pr_freeze_chan.sv
// One memory channel: outstanding-read credit, write-burst tracking,
// Avalon hold flag and strobe/waitrequest gating.
module pr_freeze_chan
    import pr_freeze_pkg::*;
#(
    parameter int BURST_W   = 5,
    parameter int MAX_OUTST = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_i,
    input  logic               k_read_i,
    input  logic               k_write_i,
    input  logic [BURST_W-1:0] k_burstcount_i,
    input  logic               m_waitrequest_i,
    input  logic               m_readdatavalid_i,
    output logic               m_read_o,
    output logic               m_write_o,
    output logic               k_waitrequest_o,
    output logic               idle_o,
    output logic               underflow_o
);

    localparam int CW = CNT_W(MAX_OUTST);
    // Sum width covers rd_cnt + burstcount without wrapping.
    localparam int SW = ((CW > BURST_W) ? CW : BURST_W) + 1;
    localparam logic [SW-1:0] MAX_S = SW'(MAX_OUTST);

    logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
    logic [BURST_W-1:0] wburst_rem_q, wburst_rem_d;
    logic               wburst_act_q, wburst_act_d;
    logic               hold_q, hold_d;

    logic               rd_gate;
    logic               wr_gate;
    logic               rd_acc;
    logic               wr_acc;
    logic [SW-1:0]      bc_ext;
    logic [SW-1:0]      sum;

    // Command gating toward memory and stall toward the kernel.
    always_comb begin
        bc_ext          = SW'(k_burstcount_i);
        rd_gate         = run_i && ((SW'(rd_cnt_q) + bc_ext) <= MAX_S);
        wr_gate         = run_i || wburst_act_q;
        m_read_o        = k_read_i  & (rd_gate | hold_q);
        m_write_o       = k_write_i & (wr_gate | hold_q);
        k_waitrequest_o = m_waitrequest_i | ~run_i;
        if (k_read_i) begin
            k_waitrequest_o = m_waitrequest_i | ~(rd_gate | hold_q);
        end else if (k_write_i) begin
            k_waitrequest_o = m_waitrequest_i | ~(wr_gate | hold_q);
        end
        rd_acc = m_read_o  & ~m_waitrequest_i;
        wr_acc = m_write_o & ~m_waitrequest_i;
        idle_o = (rd_cnt_q == '0) && !wburst_act_q && !hold_q;
    end

    // Next-state for credit counter, write burst tracker and hold flag.
    always_comb begin
        // A presented-but-stalled command must stay asserted until accepted.
        hold_d       = (m_read_o | m_write_o) & m_waitrequest_i;
        sum          = SW'(rd_cnt_q) + (rd_acc ? bc_ext : '0);
        underflow_o  = 1'b0;
        rd_cnt_d     = CW'(sum);
        if (m_readdatavalid_i) begin
            if (sum == '0) begin
                // Return with nothing outstanding: clamp and flag it.
                underflow_o = 1'b1;
                rd_cnt_d    = '0;
            end else begin
                rd_cnt_d = CW'(sum - 1'b1);
            end
        end
        wburst_rem_d = wburst_rem_q;
        wburst_act_d = wburst_act_q;
        if (wr_acc) begin
            if (!wburst_act_q) begin
                wburst_rem_d = k_burstcount_i - 1'b1;
                wburst_act_d = (k_burstcount_i > BURST_W'(1));
            end else begin
                wburst_rem_d = wburst_rem_q - 1'b1;
                if (wburst_rem_q == BURST_W'(1)) begin
                    wburst_act_d = 1'b0;
                end
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q     <= '0;
            wburst_rem_q <= '0;
            wburst_act_q <= 1'b0;
            hold_q       <= 1'b0;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            wburst_rem_q <= wburst_rem_d;
            wburst_act_q <= wburst_act_d;
            hold_q       <= hold_d;
        end
    end

endmodule

// File: rtl/pr_freeze_bridge.sv
// Drain-aware freeze bridge between the kernel region and NUM_CH
// Avalon-MM memory channels: freeze FSM, drain timeout, ack and error.
module pr_freeze_bridge
    import pr_freeze_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int DATA_W        = 512,
    parameter int ADDR_W        = 32,
    parameter int BURST_W       = 5,
    parameter int MAX_OUTST     = 64,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                         board_kernel_clk_clk,
    input  logic                         board_kernel_reset_reset_n,
    input  logic                         freeze_req,
    output logic                         freeze_ack,
    output logic                         drain_err,
    input  logic                         k_irq_in,
    output logic                         k_irq_out,
    input  logic [NUM_CH-1:0]            k_read,
    input  logic [NUM_CH-1:0]            k_write,
    input  logic [NUM_CH*ADDR_W-1:0]     k_address,
    input  logic [NUM_CH*BURST_W-1:0]    k_burstcount,
    input  logic [NUM_CH*DATA_W-1:0]     k_writedata,
    input  logic [NUM_CH*DATA_W/8-1:0]   k_byteenable,
    output logic [NUM_CH-1:0]            k_waitrequest,
    output logic [NUM_CH*DATA_W-1:0]     k_readdata,
    output logic [NUM_CH-1:0]            k_readdatavalid,
    output logic [NUM_CH-1:0]            m_read,
    output logic [NUM_CH-1:0]            m_write,
    output logic [NUM_CH*ADDR_W-1:0]     m_address,
    output logic [NUM_CH*BURST_W-1:0]    m_burstcount,
    output logic [NUM_CH*DATA_W-1:0]     m_writedata,
    output logic [NUM_CH*DATA_W/8-1:0]   m_byteenable,
    input  logic [NUM_CH-1:0]            m_waitrequest,
    input  logic [NUM_CH*DATA_W-1:0]     m_readdata,
    input  logic [NUM_CH-1:0]            m_readdatavalid
);

    localparam int TW = tmr_w(DRAIN_TIMEOUT);
    localparam logic [TW-1:0] TMR_LAST = TW'(DRAIN_TIMEOUT - 1);

    t_frz_state        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              ack_q;
    logic              err_q, err_d;
    logic              live_q;
    logic              run;
    logic [NUM_CH-1:0] ch_idle;
    logic [NUM_CH-1:0] ch_underflow;

    // Payload fields are not gated; only strobes and handshakes are.
    assign m_address    = k_address;
    assign m_burstcount = k_burstcount;
    assign m_writedata  = k_writedata;
    assign m_byteenable = k_byteenable;
    assign k_readdata   = m_readdata;

    // live_q keeps the kernel side stalled and quiet while reset is applied.
    assign run             = live_q && (state_q == RUN);
    assign k_readdatavalid = m_readdatavalid & {NUM_CH{live_q && (state_q != FROZEN)}};
    assign k_irq_out       = k_irq_in && (state_q == RUN);
    assign freeze_ack      = ack_q;
    assign drain_err       = err_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        pr_freeze_chan #(
            .BURST_W   (BURST_W),
            .MAX_OUTST (MAX_OUTST)
        ) u_chan (
            .clk               (board_kernel_clk_clk),
            .rst_n             (board_kernel_reset_reset_n),
            .run_i             (run),
            .k_read_i          (k_read[gi]),
            .k_write_i         (k_write[gi]),
            .k_burstcount_i    (k_burstcount[slice_lo(gi, BURST_W) +: BURST_W]),
            .m_waitrequest_i   (m_waitrequest[gi]),
            .m_readdatavalid_i (m_readdatavalid[gi]),
            .m_read_o          (m_read[gi]),
            .m_write_o         (m_write[gi]),
            .k_waitrequest_o   (k_waitrequest[gi]),
            .idle_o            (ch_idle[gi]),
            .underflow_o       (ch_underflow[gi])
        );
    end

    // Freeze FSM next-state, drain timer and sticky error.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q | (|ch_underflow);
        case (state_q)
            RUN: begin
                if (freeze_req) begin
                    state_d = DRAIN;
                    timer_d = '0;
                end
            end
            DRAIN: begin
                if (!freeze_req) begin
                    state_d = RUN;
                end else if (&ch_idle) begin
                    state_d = FROZEN;
                end else if (timer_q == TMR_LAST) begin
                    state_d = FROZEN;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FROZEN: begin
                if (!freeze_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // FSM, timer, ack and error registers.
    always_ff @(posedge board_kernel_clk_clk or negedge board_kernel_reset_reset_n) begin
        if (!board_kernel_reset_reset_n) begin
            state_q <= RUN;
            timer_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ack_q   <= (state_d == FROZEN);
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pr_freeze_bridge.sv
// Directed self-checking bench for pr_freeze_bridge (default parameters).
module tb_pr_freeze_bridge;

    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 512;
    localparam int ADDR_W  = 32;
    localparam int BURST_W = 5;
    localparam int BE_W    = DATA_W / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                        freeze_req;
    logic                        freeze_ack;
    logic                        drain_err;
    logic                        k_irq_in;
    logic                        k_irq_out;
    logic [NUM_CH-1:0]           k_read;
    logic [NUM_CH-1:0]           k_write;
    logic [NUM_CH*ADDR_W-1:0]    k_address;
    logic [NUM_CH*BURST_W-1:0]   k_burstcount;
    logic [NUM_CH*DATA_W-1:0]    k_writedata;
    logic [NUM_CH*BE_W-1:0]      k_byteenable;
    logic [NUM_CH-1:0]           k_waitrequest;
    logic [NUM_CH*DATA_W-1:0]    k_readdata;
    logic [NUM_CH-1:0]           k_readdatavalid;
    logic [NUM_CH-1:0]           m_read;
    logic [NUM_CH-1:0]           m_write;
    logic [NUM_CH*ADDR_W-1:0]    m_address;
    logic [NUM_CH*BURST_W-1:0]   m_burstcount;
    logic [NUM_CH*DATA_W-1:0]    m_writedata;
    logic [NUM_CH*BE_W-1:0]      m_byteenable;
    logic [NUM_CH-1:0]           m_waitrequest;
    logic [NUM_CH*DATA_W-1:0]    m_readdata;
    logic [NUM_CH-1:0]           m_readdatavalid;

    int checks = 0;
    int errors = 0;

    pr_freeze_bridge u_dut (
        .board_kernel_clk_clk       (clk),
        .board_kernel_reset_reset_n (rst_n),
        .freeze_req                 (freeze_req),
        .freeze_ack                 (freeze_ack),
        .drain_err                  (drain_err),
        .k_irq_in                   (k_irq_in),
        .k_irq_out                  (k_irq_out),
        .k_read                     (k_read),
        .k_write                    (k_write),
        .k_address                  (k_address),
        .k_burstcount               (k_burstcount),
        .k_writedata                (k_writedata),
        .k_byteenable               (k_byteenable),
        .k_waitrequest              (k_waitrequest),
        .k_readdata                 (k_readdata),
        .k_readdatavalid            (k_readdatavalid),
        .m_read                     (m_read),
        .m_write                    (m_write),
        .m_address                  (m_address),
        .m_burstcount               (m_burstcount),
        .m_writedata                (m_writedata),
        .m_byteenable               (m_byteenable),
        .m_waitrequest              (m_waitrequest),
        .m_readdata                 (m_readdata),
        .m_readdatavalid            (m_readdatavalid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bc(input int ch, input int bc);
        k_burstcount[ch*BURST_W +: BURST_W] = BURST_W'(bc);
    endtask

    initial begin
        freeze_req      = 1'b0;
        k_irq_in        = 1'b1;
        k_read          = 2'b11;
        k_write         = 2'b11;
        k_address       = '0;
        k_burstcount    = '0;
        k_writedata     = '0;
        k_byteenable    = '0;
        m_waitrequest   = 2'b00;
        m_readdata      = '0;
        m_readdatavalid = 2'b11;

        // ---- reset state (commands and returns presented during reset) ----
        #12;
        chk("rst_freeze_ack", freeze_ack, 1'b0);
        chk("rst_drain_err", drain_err, 1'b0);
        chk("rst_m_read", m_read, 2'b00);
        chk("rst_m_write", m_write, 2'b00);
        chk("rst_k_rdvalid", k_readdatavalid, 2'b00);
        chk("rst_k_waitreq", k_waitrequest, 2'b11);
        k_read = 2'b00;
        k_write = 2'b00;
        m_readdatavalid = 2'b00;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("run_idle_waitreq", k_waitrequest, 2'b00);

        // ---- idle pass-through: ch0 read bc=4, four returns ----
        k_address[31:0] = 32'h1000_0040;
        set_bc(0, 4);
        k_read = 2'b01;
        #1;
        chk("t1_m_read", m_read, 2'b01);
        chk("t1_k_waitreq", k_waitrequest, 2'b00);
        chk("t1_addr", m_address[31:0], 64'h1000_0040);
        chk("t1_bc", m_burstcount[4:0], 64'd4);
        step();
        k_read = 2'b00;
        for (int i = 0; i < 4; i++) begin
            m_readdatavalid = 2'b01;
            m_readdata[63:0] = 64'hA5A5_0000 + 64'(i);
            #1;
            chk("t1_k_rdvalid", k_readdatavalid, 2'b01);
            chk("t1_k_rddata", k_readdata[63:0], 64'hA5A5_0000 + 64'(i));
            step();
        end
        m_readdatavalid = 2'b00;
        #1;
        chk("t1_ack_idle", freeze_ack, 1'b0);
        freeze_req = 1'b1;
        step();
        chk("t1_ack_drain", freeze_ack, 1'b0);
        chk("t1_irq_drain", k_irq_out, 1'b0);
        step();
        chk("t1_ack_frozen", freeze_ack, 1'b1);
        chk("t1_err", drain_err, 1'b0);
        chk("t1_waitreq_frozen", k_waitrequest, 2'b11);
        freeze_req = 1'b0;
        step();
        chk("t1_ack_unfreeze", freeze_ack, 1'b0);
        chk("t1_irq_run", k_irq_out, 1'b1);

        // ---- drain with reads in flight on ch1 ----
        set_bc(1, 16);
        k_read = 2'b10;
        #1;
        chk("t2_m_read", m_read, 2'b10);
        step();
        k_read = 2'b00;
        m_readdatavalid = 2'b10;
        repeat (3) step();
        m_readdatavalid = 2'b00;
        freeze_req = 1'b1;
        step();
        set_bc(1, 1);
        k_read = 2'b10;
        #1;
        chk("t2_new_read_blocked", m_read, 2'b00);
        chk("t2_new_read_wait", k_waitrequest[1], 1'b1);
        for (int i = 0; i < 13; i++) begin
            m_readdatavalid = 2'b10;
            #1;
            chk("t2_ack_pending", freeze_ack, 1'b0);
            step();
        end
        m_readdatavalid = 2'b00;
        #1;
        chk("t2_ack_before", freeze_ack, 1'b0);
        step();
        chk("t2_ack_after_last", freeze_ack, 1'b1);
        chk("t2_frozen_m_read", m_read, 2'b00);
        k_read = 2'b00;
        freeze_req = 1'b0;
        step();

        // ---- write mid-burst: freeze at beat 2 of bc=8 on ch0 ----
        set_bc(0, 8);
        k_writedata[63:0] = 64'hDEAD_BEEF_0123_4567;
        k_write = 2'b01;
        #1;
        chk("t3_beat1", m_write, 2'b01);
        chk("t3_wdata", m_writedata[63:0], 64'hDEAD_BEEF_0123_4567);
        step();
        freeze_req = 1'b1;
        #1;
        chk("t3_beat2", m_write, 2'b01);
        step();
        for (int i = 3; i <= 8; i++) begin
            #1;
            chk("t3_tail_m_write", m_write, 2'b01);
            chk("t3_tail_k_wait", k_waitrequest[0], 1'b0);
            step();
        end
        #1;
        chk("t3_new_write_blocked", m_write, 2'b00);
        chk("t3_new_write_wait", k_waitrequest[0], 1'b1);
        chk("t3_ack_before", freeze_ack, 1'b0);
        step();
        chk("t3_ack", freeze_ack, 1'b1);
        chk("t3_frozen_wait", k_waitrequest[0], 1'b1);
        k_write = 2'b00;
        freeze_req = 1'b0;
        step();

        // ---- credit cap on ch0: build rd_cnt=60, then bc=8 ----
        set_bc(0, 30);
        k_read = 2'b01;
        step();
        #1;
        chk("t4_second30", m_read, 2'b01);
        step();
        set_bc(0, 8);
        m_readdatavalid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_capped", m_read, 2'b00);
            chk("t4_capped_wait", k_waitrequest[0], 1'b1);
            step();
        end
        m_readdatavalid = 2'b00;
        #1;
        chk("t4_issue_at56", m_read, 2'b01);
        chk("t4_issue_wait", k_waitrequest[0], 1'b0);
        step();
        set_bc(0, 1);
        #1;
        chk("t4_full64", m_read, 2'b00);
        k_read = 2'b00;
        m_readdatavalid = 2'b01;
        repeat (64) step();
        m_readdatavalid = 2'b00;
        freeze_req = 1'b1;
        step();
        step();
        chk("t4_drained_ack", freeze_ack, 1'b1);
        chk("t4_no_underflow", drain_err, 1'b0);
        freeze_req = 1'b0;
        step();

        // ---- timeout: ch0 bc=2 never returns ----
        set_bc(0, 2);
        k_read = 2'b01;
        step();
        k_read = 2'b00;
        freeze_req = 1'b1;
        step();
        repeat (4095) step();
        chk("t5_ack_before_timeout", freeze_ack, 1'b0);
        chk("t5_err_before_timeout", drain_err, 1'b0);
        step();
        chk("t5_ack_timeout", freeze_ack, 1'b1);
        chk("t5_err_timeout", drain_err, 1'b1);
        chk("t5_irq_masked", k_irq_out, 1'b0);
        freeze_req = 1'b0;
        step();
        chk("t5_err_sticky", drain_err, 1'b1);
        chk("t5_ack_cleared", freeze_ack, 1'b0);
        m_readdatavalid = 2'b01;
        repeat (2) step();
        m_readdatavalid = 2'b00;

        // ---- hold across freeze, then unfreeze ----
        set_bc(1, 1);
        k_read = 2'b10;
        m_waitrequest = 2'b10;
        freeze_req = 1'b1;
        #1;
        chk("t6_m_read_run", m_read, 2'b10);
        chk("t6_k_wait_run", k_waitrequest[1], 1'b1);
        step();
        chk("t6_held_1", m_read, 2'b10);
        chk("t6_held_wait", k_waitrequest[1], 1'b1);
        step();
        chk("t6_held_2", m_read, 2'b10);
        chk("t6_ack_held", freeze_ack, 1'b0);
        m_waitrequest = 2'b00;
        #1;
        chk("t6_accept_wait", k_waitrequest[1], 1'b0);
        step();
        k_read = 2'b00;
        #1;
        chk("t6_released", m_read, 2'b00);
        m_readdatavalid = 2'b10;
        #1;
        chk("t6_rdvalid_drain", k_readdatavalid, 2'b10);
        step();
        m_readdatavalid = 2'b00;
        #1;
        chk("t6_ack_before", freeze_ack, 1'b0);
        step();
        chk("t6_ack", freeze_ack, 1'b1);
        m_readdatavalid = 2'b10;
        #1;
        chk("t6_rdvalid_frozen", k_readdatavalid, 2'b00);
        m_readdatavalid = 2'b00;
        freeze_req = 1'b0;
        step();
        chk("t6_ack_unfreeze", freeze_ack, 1'b0);
        chk("t6_irq_run", k_irq_out, 1'b1);
        m_waitrequest = 2'b10;
        #1;
        chk("t6_waitreq_pass", k_waitrequest, 2'b10);
        m_waitrequest = 2'b00;

        // ---- reset clears drain_err; underflow sets it ----
        rst_n = 1'b0;
        #1;
        chk("t7_err_reset", drain_err, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        step();
        m_readdatavalid = 2'b10;
        step();
        m_readdatavalid = 2'b00;
        chk("t7_underflow_err", drain_err, 1'b1);
        chk("t7_ack", freeze_ack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
